pc_sequencer: RTL and testbench

Program-counter controller that sequences the 16-bit PC register through the shared 16-bit incrementer (INC16) and provides jump, call and return with a small return-address stack. It sits between instruction decode and the instruction-memory address bus. Each cycle it presents the current PC to the incrementer, chooses the next PC, and keeps push/pop bookkeeping and fault state.

---
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/incrementer/address-bus signal bundle for pc_sequencer
//
// Purpose: groups the command, incrementer and status signals of pc_sequencer.
//   slave  : the sequencer side (consumes commands and INC_Y, drives PC/status)
//   master : the decode / incrementer side
// Signals:
//   EN, LOAD, INC, CALL, RET  command strobes (EN gates all of them)
//   D[15:0]                   jump/call target
//   INC_A[15:0] / INC_Y[15:0] operand to / result from the shared INC16
//   PC[15:0]                  registered program counter
//   SP[$clog2(DEPTH):0]       number of valid return-stack entries
//   FAULT, OVF, UNF           fault state and sticky overflow/underflow flags
interface pc_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           EN;
  logic           LOAD;
  logic           INC;
  logic           CALL;
  logic           RET;
  logic [15:0]    D;
  logic [15:0]    INC_A;
  logic [15:0]    INC_Y;
  logic [15:0]    PC;
  logic [SPW-1:0] SP;
  logic           FAULT;
  logic           OVF;
  logic           UNF;

  modport slave (
    input  EN, LOAD, INC, CALL, RET, D, INC_Y,
    output INC_A, PC, SP, FAULT, OVF, UNF
  );

  modport master (
    output EN, LOAD, INC, CALL, RET, D, INC_Y,
    input  INC_A, PC, SP, FAULT, OVF, UNF
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with return-address stack
//
// Purpose: steps a 16-bit PC through the shared external INC16 and provides
//   jump, call and return via a DEPTH-entry LIFO return stack. Stack overflow
//   or underflow moves the block into a FAULT state that only reset leaves.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  pc_sequencer_if.slave (commands, D, INC_A/INC_Y, PC, SP, flags)
module pc_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  pc_sequencer_if.slave     bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [15:0]    pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [15:0]    stack_q [DEPTH];

  logic           push;
  logic [AW-1:0]  push_idx;
  logic [AW-1:0]  pop_idx;
  logic           stack_full;
  logic           stack_empty;

  // When not full, SP < DEPTH so its low bits address the free slot directly.
  assign push_idx    = sp_q[AW-1:0];
  assign pop_idx     = AW'(sp_q - 1'b1);
  assign stack_full  = (sp_q == SPW'(DEPTH));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (state_q == ST_RUN && bus.EN) begin
      // Priority CALL > RET > LOAD > INC; only the winner acts.
      if (bus.CALL) begin
        if (!stack_full) begin
          push = 1'b1;
          sp_d = sp_q + 1'b1;
          pc_d = bus.D;
        end else begin
          ovf_d   = 1'b1;
          state_d = ST_FAULT;
        end
      end else if (bus.RET) begin
        if (!stack_empty) begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - 1'b1;
        end else begin
          unf_d   = 1'b1;
          state_d = ST_FAULT;
        end
      end else if (bus.LOAD) begin
        pc_d = bus.D;
      end else if (bus.INC) begin
        pc_d = bus.INC_Y;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The return address is the incrementer result for the pre-edge PC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push) begin
      stack_q[push_idx] <= bus.INC_Y;
    end
  end

  assign bus.INC_A = pc_q;
  assign bus.PC    = pc_q;
  assign bus.SP    = sp_q;
  assign bus.FAULT = (state_q == ST_FAULT);
  assign bus.OVF   = ovf_q;
  assign bus.UNF   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [15:0]    pc;
    logic [SPW-1:0] sp;
    logic           fault;
    logic           ovf;
    logic           unf;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  pc_sequencer_if #(.DEPTH(DEPTH)) bus ();

  pc_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // External shared incrementer.
  assign bus.INC_Y = bus.INC_A + 16'd1;

  int   vectors_applied = 0;
  int   miscompares     = 0;
  exp_t exp_q [$];

  logic [15:0]    m_pc;
  logic [SPW-1:0] m_sp;
  logic [15:0]    m_stk [DEPTH];
  logic           m_fault;
  logic           m_ovf;
  logic           m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic load,
                            input logic inc, input logic call, input logic ret,
                            input logic [15:0] d);
    if (rst) begin
      m_pc = '0; m_sp = '0; m_fault = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    end else if (!m_fault && en) begin
      if (call) begin
        if (int'(m_sp) < DEPTH) begin
          m_stk[int'(m_sp)] = m_pc + 16'd1;
          m_sp = m_sp + 1'b1;
          m_pc = d;
        end else begin
          m_ovf = 1'b1; m_fault = 1'b1;
        end
      end else if (ret) begin
        if (m_sp != 0) begin
          m_sp = m_sp - 1'b1;
          m_pc = m_stk[int'(m_sp)];
        end else begin
          m_unf = 1'b1; m_fault = 1'b1;
        end
      end else if (load) begin
        m_pc = d;
      end else if (inc) begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic apply(input string tag, input logic rst, input logic en, input logic load,
                       input logic inc, input logic call, input logic ret,
                       input logic [15:0] d);
    exp_t e;
    RST = rst; bus.EN = en; bus.LOAD = load; bus.INC = inc;
    bus.CALL = call; bus.RET = ret; bus.D = d;
    model_step(rst, en, load, inc, call, ret, d);
    e.pc = m_pc; e.sp = m_sp; e.fault = m_fault; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".pc"},    32'(bus.PC),    32'(e.pc));
    check_eq({tag, ".inc_a"}, 32'(bus.INC_A), 32'(e.pc));
    check_eq({tag, ".sp"},    32'(bus.SP),    32'(e.sp));
    check_eq({tag, ".fault"}, 32'(bus.FAULT), 32'(e.fault));
    check_eq({tag, ".ovf"},   32'(bus.OVF),   32'(e.ovf));
    check_eq({tag, ".unf"},   32'(bus.UNF),   32'(e.unf));
  endtask

  initial begin
    bus.EN = 1'b0; bus.LOAD = 1'b0; bus.INC = 1'b0;
    bus.CALL = 1'b0; bus.RET = 1'b0; bus.D = '0;
    #2;

    // Reset then step
    apply("reset",  1, 0, 0, 0, 0, 0, 16'h0000);
    apply("inc1",   0, 1, 0, 1, 0, 0, 16'h0000);
    apply("inc2",   0, 1, 0, 1, 0, 0, 16'h0000);
    apply("inc3",   0, 1, 0, 1, 0, 0, 16'h0000);

    // Wrap and LOAD/INC priority
    apply("ld_ffff", 0, 1, 1, 0, 0, 0, 16'hFFFF);
    apply("wrap",    0, 1, 0, 1, 0, 0, 16'h0000);
    apply("ld_inc",  0, 1, 1, 1, 0, 0, 16'h1234);

    // Call/return nesting
    apply("ld_0010", 0, 1, 1, 0, 0, 0, 16'h0010);
    apply("call1",   0, 1, 0, 0, 1, 0, 16'h0100);
    apply("call2",   0, 1, 0, 0, 1, 0, 16'h0200);
    apply("ret1",    0, 1, 0, 0, 0, 1, 16'h0000);
    apply("ret2",    0, 1, 0, 0, 0, 1, 16'h0000);

    // Overflow fault
    apply("ov_c1",   0, 1, 0, 0, 1, 0, 16'h1000);
    apply("ov_c2",   0, 1, 0, 0, 1, 0, 16'h2000);
    apply("ov_c3",   0, 1, 0, 0, 1, 0, 16'h3000);
    apply("ov_c4",   0, 1, 0, 0, 1, 0, 16'h4000);
    apply("ov_c5",   0, 1, 0, 0, 1, 0, 16'h0ABC);
    apply("flt_inc", 0, 1, 0, 1, 0, 0, 16'h0000);
    apply("flt_ret", 0, 1, 0, 0, 0, 1, 16'h0000);
    apply("flt_ld",  0, 0, 1, 0, 0, 0, 16'h7777);

    // Reset overrides commands while faulted
    apply("rst_flt", 1, 1, 0, 0, 1, 0, 16'h5555);

    // Underflow and recovery
    apply("unf_ret", 0, 1, 0, 0, 0, 1, 16'h0000);
    apply("unf_inc", 0, 1, 0, 1, 0, 0, 16'h0000);
    apply("rst_unf", 1, 0, 0, 0, 0, 0, 16'h0000);
    apply("rec_inc", 0, 1, 0, 1, 0, 0, 16'h0000);

    // Enable stall and CALL+RET conflict
    apply("call_sp1", 0, 1, 0, 0, 1, 0, 16'h0300);
    apply("en0_call", 0, 0, 1, 1, 1, 1, 16'h0555);
    apply("call_ret", 0, 1, 0, 0, 1, 1, 16'h0555);
    apply("pop_a",    0, 1, 0, 0, 0, 1, 16'h0000);
    apply("pop_b",    0, 1, 0, 0, 0, 1, 16'h0000);

    // Random command mix against the model
    for (int i = 0; i < 120; i++) begin
      apply("rand",
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            16'($urandom));
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
